prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: instruction-memory capacity in 32-bit words.
REQ-002 SHALL have localparam ADDR_W, equal to clog2(DEPTH_WORDS): word-address width.
REQ-003 SHALL have port clk_PL  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_PL  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port byte_in  input  8  serial program byte.
REQ-006 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port reload  input  1  single-cycle pulse that restarts loading.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  word address.
REQ-011 SHALL have port imem_wdata  output  32  instruction word.
REQ-012 SHALL have port cpu_reset_n  output  1  active-low reset to the rv32i core.
REQ-013 SHALL have port done  output  1  program loaded and core running.
REQ-014 SHALL have port error  output  1  load failed.

Function
REQ-015 SHALL accept a byte only in a cycle where byte_valid=1 and byte_ready=1.
REQ-016 SHALL implement states HDR_LO, HDR_HI, PAYLOAD, CHECK, RUN and ERROR.
REQ-017 SHALL drive byte_ready=1 in HDR_LO, HDR_HI, PAYLOAD and CHECK, and 0 in RUN and ERROR.
REQ-018 SHALL use the stream format: N as a 16-bit little-endian word count (HDR_LO, then HDR_HI), then 4N payload bytes, then one checksum byte.
REQ-019 SHALL go from HDR_HI to ERROR if N=0 or N>DEPTH_WORDS, and otherwise to PAYLOAD.
REQ-020 SHALL pack each group of 4 payload bytes little-endian: the first byte goes to bits [7:0] and the fourth to bits [31:24].
REQ-021 SHALL pulse imem_we for exactly one cycle, the cycle after the fourth byte of a word is accepted, with registered imem_addr and imem_wdata.
REQ-022 SHALL start imem_addr at 0 for each load and increment it by 1 per word written.
REQ-023 SHALL enter CHECK after the write of word N-1 is issued; a byte accepted in that same cycle is the checksum byte.
REQ-024 SHALL compute the checksum as the XOR of all 4N payload bytes; header bytes are excluded.
REQ-025 SHALL go from CHECK to RUN when the checksum byte matches, and to ERROR otherwise; the transition happens in the cycle after acceptance.
REQ-026 SHALL hold cpu_reset_n=1 and done=1 in RUN; in all other states cpu_reset_n=0 and done=0.
REQ-027 SHALL hold error=1 in ERROR only; ERROR is left only by reload.
REQ-028 SHALL, on reload in RUN or ERROR, move to HDR_LO on the next edge and drop cpu_reset_n there; it clears the word counter, the byte counter and the checksum.
REQ-029 SHALL ignore reload in HDR_LO, HDR_HI, PAYLOAD and CHECK.
REQ-030 SHALL never assert imem_we outside PAYLOAD/CHECK-entry write cycles and never write an address >= N.
REQ-031 SHALL not clear instruction-memory contents on abort; previously written words remain.

Reset
REQ-032 SHALL, while reset_PL=0, force state HDR_LO, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, done=0, error=0 and byte_ready=0, regardless of clock.
REQ-033 SHALL treat a reset asserted mid-load as an abort: no further writes, and after release the loader awaits a new header.
REQ-034 SHALL assert byte_ready in the first cycle after reset_PL rises.

Structure
REQ-035 SHALL take its state encoding, the header length (2 bytes) and the checksum length (1 byte) from the shared rv32i package/defines file used by the core.
REQ-036 SHALL contain one sub-module, word_packer: a 2-bit byte counter, a 32-bit shift/assemble register and a word_ready pulse.
REQ-037 SHALL keep the top-level FSM, the word counter and the checksum in prog_loader.

Verification
REQ-038 SHALL test reset: hold reset_PL=0 for 3 cycles -> all outputs 0; 1 cycle after release, byte_ready=1.
REQ-039 SHALL test a good load: bytes 02 00 13 05 10 00 93 05 20 00 B0 -> writes addr0=0x00100513 and addr1=0x00200593 -> RUN with done=1 and cpu_reset_n=1.
REQ-040 SHALL test a bad checksum: the same stream with last byte B1 -> 2 writes, then error=1 with cpu_reset_n=0 and byte_ready=0.
REQ-041 SHALL test header bounds: N=0, or N=257 with default DEPTH_WORDS -> ERROR immediately after HDR_HI, zero writes.
REQ-042 SHALL test stalls: the good-load stream with byte_valid low on alternate cycles -> identical writes and final state.
REQ-043 SHALL test abort and reload: reset_PL pulsed low after 5 payload bytes -> exactly 1 write, then a fresh header accepted; reload from RUN -> cpu_reset_n=0 on the next cycle and a second load succeeds.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: stream framing lengths and FSM encoding.
package prog_loader_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned HDR_LEN  = 2;
    localparam int unsigned CSUM_LEN = 1;
    localparam int unsigned HDR_W    = HDR_LEN * BYTE_W;
    localparam int unsigned CSUM_W   = CSUM_LEN * BYTE_W;

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5
    } pl_state_e;

    // The loader takes bytes in every state except the two terminal ones.
    function automatic logic takes_bytes(input pl_state_e s);
        return (s != RUN) && (s != ERROR);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles four accepted bytes little-endian into a word and pulses word_ready once it is complete.
module word_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              feed,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              last_c,
    output logic              word_ready,
    output logic [WORD_W-1:0] word
);

    logic [1:0] byte_cnt;

    assign last_c = (byte_cnt == 2'd3);

    // Bytes enter at the top and shift down, so the first byte ends in [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 2'd0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clr) begin
                byte_cnt <= 2'd0;
            end else if (feed) begin
                word       <= {byte_in, word[WORD_W-1:BYTE_W]};
                byte_cnt   <= byte_cnt + 2'd1;
                word_ready <= last_c;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into instruction memory,
// then releases the core from reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic         clk_PL,
    input  logic         reset_PL,
    input  logic         reload,
    prog_loader_if.slave bus,
    output logic         cpu_reset_n,
    output logic         done,
    output logic         error
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    pl_state_e         state;
    pl_state_e         state_nxt_c;
    logic [BYTE_W-1:0] n_lo;
    logic [HDR_W-1:0]  n_words;
    logic [HDR_W-1:0]  word_cnt;
    logic [HDR_W-1:0]  hdr_n_c;
    logic [CSUM_W-1:0] csum;
    logic              byte_ready;
    logic              accept_c;
    logic              feed_c;
    logic              clr_c;
    logic              last_c;
    logic              word_ready;
    logic [WORD_W-1:0] word;

    assign accept_c = bus.byte_valid && byte_ready;
    assign feed_c   = accept_c && (state == PAYLOAD);
    assign clr_c    = reload && ((state == RUN) || (state == ERROR));
    assign hdr_n_c  = {bus.byte_in, n_lo};

    word_packer u_packer (
        .clk        (clk_PL),
        .rst_n      (reset_PL),
        .clr        (clr_c),
        .feed       (feed_c),
        .byte_in    (bus.byte_in),
        .last_c     (last_c),
        .word_ready (word_ready),
        .word       (word)
    );

    assign bus.byte_ready = byte_ready;
    assign bus.imem_we    = word_ready;
    assign bus.imem_addr  = ADDR_W'(word_cnt);
    assign bus.imem_wdata = word;

    // The last word's write lands in the first CHECK cycle, so the checksum byte may follow at once.
    always_comb begin
        state_nxt_c = state;
        case (state)
            HDR_LO:  if (accept_c) state_nxt_c = HDR_HI;
            HDR_HI:  if (accept_c) begin
                         state_nxt_c = ((hdr_n_c == '0) || (hdr_n_c > HDR_W'(DEPTH_WORDS)))
                                       ? ERROR : PAYLOAD;
                     end
            PAYLOAD: if (feed_c && last_c && (word_cnt == n_words - HDR_W'(1))) state_nxt_c = CHECK;
            CHECK:   if (accept_c) state_nxt_c = (bus.byte_in == csum) ? RUN : ERROR;
            RUN,
            ERROR:   if (reload) state_nxt_c = HDR_LO;
            default: state_nxt_c = HDR_LO;
        endcase
    end

    always_ff @(posedge clk_PL or negedge reset_PL) begin
        if (!reset_PL) begin
            state       <= HDR_LO;
            byte_ready  <= 1'b0;
            cpu_reset_n <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            n_lo        <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            csum        <= '0;
        end else begin
            state       <= state_nxt_c;
            byte_ready  <= takes_bytes(state_nxt_c);
            cpu_reset_n <= (state_nxt_c == RUN);
            done        <= (state_nxt_c == RUN);
            error       <= (state_nxt_c == ERROR);

            if ((state == HDR_LO) && accept_c) n_lo <= bus.byte_in;
            if ((state == HDR_HI) && accept_c) begin
                n_words  <= hdr_n_c;
                word_cnt <= '0;
                csum     <= '0;
            end
            if (feed_c)     csum     <= csum ^ bus.byte_in;
            if (word_ready) word_cnt <= word_cnt + HDR_W'(1);
            if (clr_c) begin
                word_cnt <= '0;
                csum     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed vector table, randomized streams against a
// stream-level reference model, and hand-written abort/reload sequences.
module tb_prog_loader;

    localparam int DEPTH  = 256;
    localparam int F_PEND = 0;
    localparam int F_RUN  = 1;
    localparam int F_ERR  = 2;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [95:0] bytes;
        int          len;
        int          gap;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        int          fin;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic reload;
    logic cpu_reset_n;
    logic done;
    logic error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] exp_q[$];

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk_PL      (clk),
        .reset_PL    (rst_n),
        .reload      (reload),
        .bus         (bus),
        .cpu_reset_n (cpu_reset_n),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endfunction

    // Reference: header gives N, payload packs little-endian, checksum is XOR of payload bytes.
    function automatic int model(input byte_q_t s);
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        n = int'({s[1], s[0]});
        if (n == 0 || n > DEPTH) return F_ERR;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            w = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
            exp_q.push_back(w);
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        return (s[2+4*n] == x) ? F_RUN : F_ERR;
    endfunction

    function automatic void chk_final(input string tag, input int fin);
        chk($sformatf("%s.done", tag),        done,           32'(fin == F_RUN));
        chk($sformatf("%s.cpu_reset_n", tag), cpu_reset_n,    32'(fin == F_RUN));
        chk($sformatf("%s.error", tag),       error,          32'(fin == F_ERR));
        chk($sformatf("%s.byte_ready", tag),  bus.byte_ready, 32'(fin == F_PEND));
    endfunction

    task automatic do_reset(input int cycles);
        rst_n          = 1'b0;
        reload         = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit rl, output bit ok);
        int n;
        n              = 0;
        ok             = 1'b0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        reload         = rl;
        while (!ok && n < 20) begin
            if (bus.byte_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
            n++;
        end
        bus.byte_valid = 1'b0;
        reload         = 1'b0;
    endtask

    task automatic run_stream(input byte_q_t s, input int gap, input bit noise, input int fin,
                              input string tag);
        bit ok;
        bit all_ok;
        int g;
        all_ok = 1'b1;
        wa_q.delete();
        wd_q.delete();
        foreach (s[i]) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) @(negedge clk);
            send_byte(s[i], noise && ($urandom_range(0, 3) == 0), ok);
            if (!ok) all_ok = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk($sformatf("%s.accepted", tag), 32'(all_ok), 32'd1);
        chk($sformatf("%s.nwrites", tag), wa_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wa_q.size(); k++) begin
            chk($sformatf("%s.addr%0d", tag, k), wa_q[k], 32'(k));
            chk($sformatf("%s.data%0d", tag, k), wd_q[k], exp_q[k]);
        end
        chk_final(tag, fin);
    endtask

    task automatic reload_and_check(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk($sformatf("%s.cpu_reset_n", tag), cpu_reset_n,    32'd0);
        chk($sformatf("%s.done", tag),        done,           32'd0);
        chk($sformatf("%s.error", tag),       error,          32'd0);
        chk($sformatf("%s.byte_ready", tag),  bus.byte_ready, 32'd1);
        chk($sformatf("%s.addr", tag),        bus.imem_addr,  32'd0);
    endtask

    task automatic run_table();
        vec_t       tbl[7];
        byte_q_t    s;
        logic [7:0] b;
        tbl[0] = '{96'h02_00_13_05_10_00_93_05_20_00_B0, 11, 0, 2, 32'h00100513, 32'h00200593, F_RUN};
        tbl[1] = '{96'h02_00_13_05_10_00_93_05_20_00_B1, 11, 0, 2, 32'h00100513, 32'h00200593, F_ERR};
        tbl[2] = '{96'h00_00, 2, 0, 0, 32'h0, 32'h0, F_ERR};
        tbl[3] = '{96'h01_01, 2, 0, 0, 32'h0, 32'h0, F_ERR};
        tbl[4] = '{96'h02_00_13_05_10_00_93_05_20_00_B0, 11, 1, 2, 32'h00100513, 32'h00200593, F_RUN};
        tbl[5] = '{96'h00_01, 2, 0, 0, 32'h0, 32'h0, F_PEND};
        tbl[6] = '{96'h01_00_AA_BB_CC_DD_00, 7, 0, 1, 32'hDDCCBBAA, 32'h0, F_RUN};
        foreach (tbl[t]) begin
            do_reset(2);
            s.delete();
            for (int i = 0; i < tbl[t].len; i++) begin
                b = tbl[t].bytes[8*(tbl[t].len-1-i) +: 8];
                s.push_back(b);
            end
            exp_q.delete();
            if (tbl[t].nwr > 0) exp_q.push_back(tbl[t].w0);
            if (tbl[t].nwr > 1) exp_q.push_back(tbl[t].w1);
            run_stream(s, tbl[t].gap, 1'b0, tbl[t].fin, $sformatf("vec%0d", t));
        end
    endtask

    task automatic run_random();
        byte_q_t    s;
        int         n;
        int         kind;
        int         fin;
        logic [7:0] cs;
        logic [7:0] b;
        do_reset(2);
        for (int it = 0; it < 24; it++) begin
            s.delete();
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      n = 0;
            else if (kind == 1) n = 257 + int'($urandom_range(0, 1000));
            else                n = int'($urandom_range(1, 6));
            s.push_back(n[7:0]);
            s.push_back(n[15:8]);
            if (n >= 1 && n <= DEPTH) begin
                cs = 8'h00;
                for (int k = 0; k < 4 * n; k++) begin
                    b = 8'($urandom);
                    cs = cs ^ b;
                    s.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
                s.push_back(cs);
            end
            fin = model(s);
            run_stream(s, -1, 1'b1, fin, $sformatf("rnd%0d", it));
            reload_and_check($sformatf("rnd%0d.reload", it));
        end
    endtask

    task automatic run_abort_reload();
        byte_q_t s;
        bit      ok;
        int      fin;
        do_reset(2);
        wa_q.delete();
        wd_q.delete();
        s = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        foreach (s[i]) send_byte(s[i], 1'b0, ok);
        chk("abort.we_pulse", bus.imem_we,    32'd1);
        chk("abort.we_addr",  bus.imem_addr,  32'd0);
        chk("abort.we_data",  bus.imem_wdata, 32'h00100513);
        send_byte(8'h93, 1'b0, ok);
        chk("abort.we_single", bus.imem_we, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.rst_ready", bus.byte_ready, 32'd0);
        chk("abort.rst_we",    bus.imem_we,    32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort.nwrites", wa_q.size(), 32'd1);
        chk_final("abort.idle", F_PEND);

        s   = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        fin = model(s);
        run_stream(s, 0, 1'b0, fin, "abort.fresh");
        reload_and_check("run.reload");
        s   = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        fin = model(s);
        run_stream(s, 0, 1'b0, fin, "run.second");
    endtask

    initial begin
        rst_n          = 1'b0;
        reload         = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.byte_ready",  bus.byte_ready, 32'd0);
        chk("rst.imem_we",     bus.imem_we,    32'd0);
        chk("rst.imem_addr",   bus.imem_addr,  32'd0);
        chk("rst.imem_wdata",  bus.imem_wdata, 32'd0);
        chk("rst.cpu_reset_n", cpu_reset_n,    32'd0);
        chk("rst.done",        done,           32'd0);
        chk("rst.error",       error,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_after", bus.byte_ready, 32'd1);

        run_table();
        run_random();
        run_abort_reload();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
